// File: rtl/riscv_pkg.sv
// Shared RV64 encoding constants, instruction-kind enum and immediate range checks.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;

    typedef enum logic [1:0] {
        KIND_LOAD   = 2'b00,
        KIND_STORE  = 2'b01,
        KIND_BRANCH = 2'b10,
        KIND_RTYPE  = 2'b11
    } kind_e;

    // True when imm is exactly the sign extension of its low 12 bits.
    function automatic logic fits_imm12(input logic [63:0] imm);
        return imm == {{52{imm[11]}}, imm[11:0]};
    endfunction

    // True when imm is exactly the sign extension of its low 13 bits
    // (alignment is checked separately by the branch packer).
    function automatic logic fits_imm13(input logic [63:0] imm);
        return imm == {{51{imm[12]}}, imm[12:0]};
    endfunction

endpackage

// File: rtl/imm_packer.sv
// Combinational packer: decoded fields -> 32-bit RV instruction word plus a
// legality flag saying whether the immediate is representable in the format.
module imm_packer
    import riscv_pkg::*;
(
    input  logic [1:0]  kind,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [63:0] imm,
    output logic [31:0] word,
    output logic        legal
);

    // Select the bit layout for the instruction kind and judge the immediate.
    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (kind)
            KIND_LOAD: begin
                word  = {imm[11:0], rs1, funct3, rd, OP_LOAD};
                legal = fits_imm12(imm);
            end
            KIND_STORE: begin
                word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
                legal = fits_imm12(imm);
            end
            KIND_BRANCH: begin
                word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
                legal = fits_imm13(imm) && !imm[0];
            end
            default: begin
                word  = {funct7, rs2, rs1, funct3, rd, OP_RTYPE};
                legal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Sequential instruction encoder: accepts field bundles, packs legal ones into
// words tagged with an incrementing address, and buffers them in a small FIFO.
// Illegal immediates are dropped and recorded in a sticky flag and counter.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR  = 64'h0,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  kind,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [63:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_addr,
    output logic        err,
    output logic [7:0]  err_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    logic [31:0]      word;
    logic             legal;
    logic             accept, push, reject, pop;

    logic [31:0]      instr_mem_q [FIFO_DEPTH];
    logic [31:0]      instr_mem_d [FIFO_DEPTH];
    logic [63:0]      addr_mem_q  [FIFO_DEPTH];
    logic [63:0]      addr_mem_d  [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [63:0]      addr_cnt_q, addr_cnt_d;
    logic             err_q, err_d;
    logic [7:0]       err_count_q, err_count_d;

    imm_packer u_packer (
        .kind   (kind),
        .rd     (rd),
        .rs1    (rs1),
        .rs2    (rs2),
        .funct3 (funct3),
        .funct7 (funct7),
        .imm    (imm),
        .word   (word),
        .legal  (legal)
    );

    // Handshake: readiness comes only from registered occupancy and flush.
    always_comb begin
        in_ready  = (count_q != DEPTH_CNT) && !flush;
        out_valid = (count_q != '0);
        out_instr = out_valid ? instr_mem_q[rd_ptr_q] : '0;
        out_addr  = out_valid ? addr_mem_q[rd_ptr_q]  : '0;
        err       = err_q;
        err_count = err_count_q;
        accept    = in_valid && in_ready;
        push      = accept && legal;
        reject    = accept && !legal;
        pop       = out_valid && out_ready;
    end

    // Next-state for FIFO, address counter and error tracking; flush clears
    // the queue and address but deliberately keeps the error history.
    always_comb begin
        instr_mem_d = instr_mem_q;
        addr_mem_d  = addr_mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        addr_cnt_d  = addr_cnt_q;
        err_d       = err_q | reject;
        err_count_d = (reject && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            addr_cnt_d = BASE_ADDR;
        end else begin
            if (push) begin
                instr_mem_d[wr_ptr_q] = word;
                addr_mem_d[wr_ptr_q]  = addr_cnt_q;
                wr_ptr_d              = wr_ptr_q + 1'b1;
                addr_cnt_d            = addr_cnt_q + 64'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Per-entry storage registers, cleared on reset so no stale word survives.
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    instr_mem_q[gi] <= '0;
                    addr_mem_q[gi]  <= '0;
                end else begin
                    instr_mem_q[gi] <= instr_mem_d[gi];
                    addr_mem_q[gi]  <= addr_mem_d[gi];
                end
            end
        end
    endgenerate

    // Control state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            addr_cnt_q  <= BASE_ADDR;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            addr_cnt_q  <= addr_cnt_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus pushes expected {word, addr},
// a negedge monitor pops and compares on every output handshake.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  kind = 2'b00;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [63:0] imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [63:0] out_addr;
    logic        err;
    logic [7:0]  err_count;

    typedef struct packed {
        logic [31:0] w;
        logic [63:0] a;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] exp_addr = 64'h0;
    int          n_checks = 0;
    int          n_fail = 0;

    instr_encoder #(.BASE_ADDR(64'h0), .FIFO_DEPTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .kind      (kind),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .funct7    (funct7),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .err       (err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    // Monitor: every output handshake must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got instr %h addr %h expected nothing", out_instr, out_addr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (out_instr !== e.w || out_addr !== e.a) begin
                    n_fail++;
                    $display("FAIL pop_word: got instr %h addr %h expected instr %h addr %h",
                             out_instr, out_addr, e.w, e.a);
                end else begin
                    $display("ok   pop instr %h addr %h", out_instr, out_addr);
                end
            end
        end
    end

    task automatic drive(input logic [1:0] k, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [63:0] im);
        kind = k; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
        in_valid = 1'b1;
    endtask

    // Wait (bounded) until the driven bundle is accepted; legal ones go to the scoreboard.
    task automatic wait_accept(input logic legal, input logic [31:0] w);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL accept_timeout: got in_ready %b expected 1", in_ready);
        end else if (legal) begin
            exp_q.push_back({w, exp_addr});
            exp_addr = exp_addr + 64'd4;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [1:0] k, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [63:0] im, input logic legal, input logic [31:0] w);
        drive(k, d, s1, s2, f3, f7, im);
        wait_accept(legal, w);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        idle(3);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_instr", 64'(out_instr), 64'h0);
        chk("rst_out_addr", out_addr, 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        chk("rst_err_count", 64'(err_count), 64'h0);
        reset = 1'b1;
        idle(1);
        chk("rst_in_ready", 64'(in_ready), 64'h1);

        // Basic formats, out_ready high
        send(2'b00, 5'd5, 5'd2, 5'd0, 3'b011, 7'd0, -64'sd8, 1'b1, 32'hFF813283);
        chk("load_latency_valid", 64'(out_valid), 64'h1);
        chk("load_latency_instr", 64'(out_instr), 64'hFF813283);
        chk("load_err", 64'(err), 64'h0);
        send(2'b01, 5'd0, 5'd2, 5'd6, 3'b011, 7'd0, 64'd16, 1'b1, 32'h00613823);
        send(2'b11, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 64'd0, 1'b1, 32'h002081B3);
        send(2'b10, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, -64'sd4, 1'b1, 32'hFE208EE3);
        idle(3);

        // Illegal immediates
        send(2'b10, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 64'd3, 1'b0, 32'h0);
        chk("bad_branch_err", 64'(err), 64'h1);
        chk("bad_branch_no_out", 64'(out_valid), 64'h0);
        send(2'b00, 5'd5, 5'd2, 5'd0, 3'b011, 7'd0, 64'd2048, 1'b0, 32'h0);
        chk("bad_load_err_count", 64'(err_count), 64'h2);
        chk("bad_load_no_out", 64'(out_valid), 64'h0);
        send(2'b11, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 64'd0, 1'b1, 32'h002081B3);
        chk("addr_after_err", out_addr, 64'h10);
        idle(3);

        // Backpressure: two fit, third waits
        out_ready = 1'b0;
        send(2'b00, 5'd1, 5'd0, 5'd0, 3'b010, 7'd0, 64'd4, 1'b1, 32'h00402083);
        send(2'b01, 5'd0, 5'd0, 5'd1, 3'b010, 7'd0, 64'd8, 1'b1, 32'h00102423);
        drive(2'b11, 5'd4, 5'd5, 5'd6, 3'b000, 7'b0100000, 64'd0);
        @(negedge clk);
        chk("full_in_ready", 64'(in_ready), 64'h0);
        chk("stall_head_addr", out_addr, 64'h14);
        @(negedge clk);
        chk("stall_head_stable", 64'(out_instr), 64'h00402083);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_accept(1'b1, 32'h40628233);
        idle(4);

        // Flush with FIFO full and a bundle offered
        out_ready = 1'b0;
        send(2'b00, 5'd1, 5'd0, 5'd0, 3'b010, 7'd0, 64'd4, 1'b1, 32'h00402083);
        send(2'b00, 5'd1, 5'd0, 5'd0, 3'b010, 7'd0, 64'd4, 1'b1, 32'h00402083);
        drive(2'b11, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 64'd0);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 64'(in_ready), 64'h0);
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        exp_addr = 64'h0;
        chk("flush_empty", 64'(out_valid), 64'h0);
        chk("flush_err_kept", 64'(err), 64'h1);
        chk("flush_err_count_kept", 64'(err_count), 64'h2);
        out_ready = 1'b1;
        send(2'b00, 5'd5, 5'd2, 5'd0, 3'b011, 7'd0, -64'sd8, 1'b1, 32'hFF813283);
        chk("flush_next_addr", out_addr, 64'h0);
        idle(3);

        // Asynchronous reset with one entry queued
        out_ready = 1'b0;
        send(2'b01, 5'd0, 5'd2, 5'd6, 3'b011, 7'd0, 64'd16, 1'b1, 32'h00613823);
        chk("pre_reset_valid", 64'(out_valid), 64'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'h0);
        chk("async_rst_instr", 64'(out_instr), 64'h0);
        chk("async_rst_err", 64'(err), 64'h0);
        chk("async_rst_err_count", 64'(err_count), 64'h0);
        exp_q.delete();
        exp_addr = 64'h0;
        @(posedge clk); #3;
        reset = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        chk("post_rst_in_ready", 64'(in_ready), 64'h1);
        send(2'b11, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 64'd0, 1'b1, 32'h002081B3);
        chk("post_rst_addr", out_addr, 64'h0);
        send(2'b10, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, -64'sd4, 1'b1, 32'hFE208EE3);
        idle(4);

        chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential RV64 instruction encoder for the load, store, branch and R-type formats. It accepts decoded instruction fields over a valid/ready handshake and checks that the immediate fits the format. Legal instructions are packed into 32-bit words, each tagged with a sequentially incremented instruction-memory address. Words are buffered in a 2-entry output FIFO that feeds the instruction-memory preload / self-test path ahead of the pipeline's fetch stage.

## Interface
- BASE_ADDR, 64'h0, address tagged on the first word after reset or flush.
- FIFO_DEPTH, 2, output buffer entries (power of two, ≥2).
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of FIFO and address counter.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  bundle accepted when in_valid && in_ready at a rising edge.
- kind  in  2  00 load, 01 store, 10 branch, 11 R-type.
- rd, rs1, rs2  in  5 each  register indices (ignored where the format lacks them).
- funct3  in  3  funct3 field.
- funct7  in  7  R-type only.
- imm  in  64  signed byte offset.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer pops head when out_valid && out_ready.
- out_instr  out  32  encoded word.
- out_addr  out  64  word address.
- err  out  1  sticky range error.
- err_count  out  8  rejected-bundle count, saturating at 255.

## Operation
- Opcodes: load 0000011, store 0100011, branch 1100011, R-type 0110011.
- Packing:
  - load: imm[11:0], rs1, f3, rd, op.
  - store: imm[11:5], rs2, rs1, f3, imm[4:0], op.
  - branch: imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op.
  - R-type: f7, rs2, rs1, f3, rd, op.
- Range check:
  - load/store are legal iff sign-extending imm[11:0] to 64 bits reproduces imm.
  - branch is legal iff imm[0]==0 and sign-extending imm[12:0] reproduces imm.
  - R-type ignores imm.
- Accepted legal bundle:
  - {word, addr_cnt} is pushed into the FIFO.
  - addr_cnt += 4, wrapping modulo 2^64.
- Accepted illegal bundle:
  - no push and addr_cnt unchanged.
  - err is set.
  - err_count increments, saturating.
- in_ready = !full && !flush. A legal push at the same edge as a pop on a full FIFO cannot occur because in_ready is already low.
- Simultaneous push and pop on a non-full, non-empty FIFO: occupancy is unchanged and order is preserved.
- flush:
  - wins over all other activity in that cycle; the input is not accepted.
  - FIFO is emptied and addr_cnt returns to BASE_ADDR.
  - err and err_count are retained.
- Reset (asynchronous assert, including mid-transfer):
  - FIFO empty, out_valid=0, out_instr=0, out_addr=0.
  - addr_cnt=BASE_ADDR, err=0, err_count=0.
  - in_ready=1 once deasserted.
  - No partial word survives.

## Timing
- Latency: a bundle accepted at edge N appears on out_* after edge N (visible cycle N+1) when the FIFO was empty.
- out_instr/out_addr hold stable while out_valid && !out_ready.
- in_ready depends only on registered occupancy and flush, with no combinational path from out_ready.
- Sustained throughput is 1 word per cycle with out_ready held high.
- err rises the cycle after the illegal acceptance.

## Structure
- Shared package riscv_pkg holds:
  - opcode constants (OP_LOAD, OP_STORE, OP_BRANCH, OP_RTYPE)
  - kind enum
  - IMM12/IMM13 range-check functions
- Sub-module imm_packer: combinational fields→word and legality flag; it is the exact inverse of the pipeline's immediate extraction.
- The FIFO and counters live in instr_encoder.

## Test plan
- Load, rd=5, rs1=2, f3=011, imm=-8 → out_instr=0xFF813283, out_addr=BASE_ADDR, err=0.
- Store, rs2=6, rs1=2, f3=011, imm=16 → 0x00613823 at BASE_ADDR+4; R-type add rd=3, rs1=1, rs2=2 → 0x002081B3 at BASE_ADDR+8.
- Branch, rs1=1, rs2=2, f3=000, imm=-4 → 0xFE208EE3; branch imm=3 and load imm=2048 → no output, err=1, err_count=2, next legal word at an unchanged address.
- out_ready=0 and three legal bundles → two accepted, in_ready=0 on the third; release out_ready → words popped in order, third accepted.
- flush with FIFO full and in_valid=1 → FIFO empty next cycle, bundle dropped, next word at BASE_ADDR, err retained.
- reset asserted asynchronously between edges with 1 entry queued → out_valid=0 immediately; after release, first word at BASE_ADDR and err_count=0.
